// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the MMIO UART transmit queue: register offsets,
// STATUS/CTRL bit positions and the state encodings of both state machines.
package uart_mmio_pkg;

  // Offsets relative to REG_BASE
  localparam logic [31:0] OFF_TAIL   = 32'h00;
  localparam logic [31:0] OFF_HEAD   = 32'h04;
  localparam logic [31:0] OFF_STATUS = 32'h08;
  localparam logic [31:0] OFF_DIV    = 32'h0C;
  localparam logic [31:0] OFF_CTRL   = 32'h10;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 16;

  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_IRQ_EN  = 2;

  typedef enum logic [1:0] {DR_IDLE, DR_FETCH, DR_WAIT, DR_SEND} drain_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serialiser, LSB first. Divisor and data are captured on an accepted start,
// so a divisor change never disturbs a frame already on the line.
module uart_tx_core
  import uart_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] divisor,
  input  logic        start,
  input  logic [7:0]  data,
  output logic        ready,
  output logic        uart_tx
);

  tx_state_e   state_q, state_d;
  logic [15:0] div_q;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        bit_done;

  assign bit_done = (cnt == div_q - 16'd1);
  assign ready    = (state_q == TX_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state_q <= TX_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:  if (start) state_d = TX_START;
      TX_START: if (bit_done) state_d = TX_DATA;
      TX_DATA:  if (bit_done && bit_idx == 3'd7) state_d = TX_STOP;
      TX_STOP:  if (bit_done) state_d = TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= 16'd2;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (state_q == TX_IDLE) begin
      cnt     <= '0;
      bit_idx <= '0;
      if (start) begin
        div_q <= divisor;
        shreg <= data;
      end
    end else if (bit_done) begin
      cnt <= '0;
      if (state_q == TX_DATA) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 3'd1;
      end
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  always_comb begin
    case (state_q)
      TX_START: uart_tx = 1'b0;
      TX_DATA:  uart_tx = shreg[0];
      default:  uart_tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/mmio_uart_tx_queue.sv
// MMIO transmit queue: byte ring buffer filled by software, drained through
// uart_tx_core by a four-state fetch/wait/send machine.
module mmio_uart_tx_queue
  import uart_mmio_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter logic [31:0] REG_BASE    = 32'h100,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        input_cmd_start,
  input  logic        input_cmd_write,
  output logic        output_cmd_ready,
  input  logic [31:0] input_addr,
  input  logic [31:0] input_wdata,
  output logic [31:0] output_rdata,
  output logic        output_rdata_valid,
  output logic        uart_tx,
  output logic        irq
);

  localparam int PW     = $clog2(DEPTH) + 1;
  localparam int WW     = $clog2(DEPTH) - 2;
  localparam int NWORDS = DEPTH / 4;

  logic [31:0]   mem [NWORDS];
  logic [PW-1:0] head, tail, count, tail_dist;
  logic          overflow, irq_en;
  logic [15:0]   divisor;
  drain_state_e  state_q, state_d;
  logic [31:0]   fetch_word;
  logic          core_ready, core_start;
  logic [7:0]    core_data;

  logic [31:0]   addr_w, reg_off, reg_rd;
  logic [WW-1:0] buf_word;
  logic          is_buf, wr_en, rd_en;
  logic          wr_tail, wr_div, wr_ctrl, flush, clr_ovf, tail_ok;
  logic          empty, full, busy;
  logic [1:0]    unused_addr_lo;

  assign unused_addr_lo   = input_addr[1:0];
  assign output_cmd_ready = 1'b1;

  assign addr_w   = {input_addr[31:2], 2'b00};
  assign reg_off  = addr_w - REG_BASE;
  assign is_buf   = addr_w < 32'(DEPTH);
  assign buf_word = addr_w[WW+1:2];
  assign wr_en    = input_cmd_start & input_cmd_write;
  assign rd_en    = input_cmd_start & ~input_cmd_write;
  assign wr_tail  = wr_en && (reg_off == OFF_TAIL);
  assign wr_div   = wr_en && (reg_off == OFF_DIV);
  assign wr_ctrl  = wr_en && (reg_off == OFF_CTRL);
  assign flush    = wr_ctrl & input_wdata[CTRL_FLUSH];
  assign clr_ovf  = wr_ctrl & input_wdata[CTRL_CLR_OVF];

  // A TAIL write may move anywhere within DEPTH bytes ahead of head.
  assign tail_dist = input_wdata[PW-1:0] - head;
  assign tail_ok   = tail_dist <= PW'(DEPTH);

  assign count = tail - head;
  assign empty = (count == '0);
  assign full  = (count == PW'(DEPTH));
  assign busy  = (state_q != DR_IDLE) || !core_ready;
  assign irq   = irq_en & empty & ~busy;

  always_comb begin
    reg_rd = '0;
    case (reg_off)
      OFF_TAIL: reg_rd[PW-1:0] = tail;
      OFF_HEAD: reg_rd[PW-1:0] = head;
      OFF_STATUS: begin
        reg_rd[ST_COUNT_LSB +: PW] = count;
        reg_rd[ST_OVF]   = overflow;
        reg_rd[ST_BUSY]  = busy;
        reg_rd[ST_FULL]  = full;
        reg_rd[ST_EMPTY] = empty;
      end
      OFF_DIV:  reg_rd[15:0] = divisor;
      OFF_CTRL: reg_rd[CTRL_IRQ_EN] = irq_en;
      default:  reg_rd = '0;
    endcase
  end

  // Buffer RAM; the fetch port reads pre-write data on a same-word collision.
  always_ff @(posedge clk) begin
    if (wr_en && is_buf) mem[buf_word] <= input_wdata;
    if (state_q == DR_FETCH) fetch_word <= mem[head[PW-2:2]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= DR_IDLE;
      head               <= '0;
      tail               <= '0;
      overflow           <= 1'b0;
      irq_en             <= 1'b0;
      divisor            <= DEFAULT_DIV;
      output_rdata       <= '0;
      output_rdata_valid <= 1'b0;
    end else begin
      state_q            <= state_d;
      output_rdata_valid <= rd_en;
      if (rd_en) output_rdata <= is_buf ? mem[buf_word] : reg_rd;

      // Flush wins over the drain increment.
      if (flush)                   head <= tail;
      else if (state_q == DR_SEND) head <= head + 1'b1;

      if (wr_tail && tail_ok) tail <= input_wdata[PW-1:0];

      if (clr_ovf)             overflow <= 1'b0;
      if (wr_tail && !tail_ok) overflow <= 1'b1;

      if (wr_div)  divisor <= (input_wdata[15:0] < 16'd2) ? 16'd2 : input_wdata[15:0];
      if (wr_ctrl) irq_en  <= input_wdata[CTRL_IRQ_EN];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DR_IDLE:  if (!empty && !flush) state_d = DR_FETCH;
      DR_FETCH: state_d = flush ? DR_IDLE : DR_WAIT;
      DR_WAIT: begin
        if (flush)           state_d = DR_IDLE;
        else if (core_ready) state_d = DR_SEND;
      end
      DR_SEND:  state_d = DR_IDLE;
      default:  state_d = DR_IDLE;
    endcase
  end

  assign core_start = (state_q == DR_SEND);
  assign core_data  = fetch_word[{head[1:0], 3'b000} +: 8];

  uart_tx_core u_core (
    .clk     (clk),
    .reset   (reset),
    .divisor (divisor),
    .start   (core_start),
    .data    (core_data),
    .ready   (core_ready),
    .uart_tx (uart_tx)
  );

endmodule
